// File: rtl/vsynth_nco_pkg.sv
// Shared NCO subsystem constants and types for the wavetable offset ROM.
package vsynth_nco_pkg;

    localparam int WT_ROM_SIZE = 29;
    localparam int WT_ADDR_W   = 5;
    localparam int WT_DATA_W   = 8;

    typedef logic [WT_ADDR_W-1:0] wt_addr_t;
    typedef logic [WT_DATA_W-1:0] wt_data_t;

    function automatic logic addr_in_range(input wt_addr_t addr);
        return (int'(addr) < WT_ROM_SIZE);
    endfunction

endpackage

// File: rtl/rr_priority_select.sv
// Combinational round-robin pick: first active request at or after ptr, wrapping.
module rr_priority_select #(
    parameter int NUM_REQ = 8,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [ID_W-1:0]    o_idx,
    output logic               o_any
);

    // Scan NUM_REQ positions starting at the pointer; the first hit wins.
    always_comb begin
        int j;
        j       = 0;
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = (int'(i_ptr) + k) % NUM_REQ;
            if (!o_any && i_req[j]) begin
                o_any      = 1'b1;
                o_grant[j] = 1'b1;
                o_idx      = ID_W'(j);
            end else begin
                o_any = o_any;
            end
        end
    end

endmodule

// File: rtl/wavetable_offset_arbiter.sv
// Round-robin arbiter sharing the wavetable offset ROM among NCO voices.
// Optional range check enabled by defining WAVETABLE_OFFSET_RANGE_CHECK_EN.
module wavetable_offset_arbiter
    import vsynth_nco_pkg::*;
#(
    parameter int NUM_REQ = 8,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_en,
    input  logic [NUM_REQ-1:0]           i_req,
    input  logic [NUM_REQ*WT_ADDR_W-1:0] i_wave_sel,
    output logic [NUM_REQ-1:0]           o_grant,
    output logic                         o_rom_re,
    output logic [WT_ADDR_W-1:0]         o_rom_addr,
    input  logic [WT_DATA_W-1:0]         i_rom_data,
    output logic                         o_rd_valid,
    output logic [ID_W-1:0]              o_rd_id,
    output logic [WT_DATA_W-1:0]         o_rd_data,
    output logic                         o_rd_err
);

    logic [ID_W-1:0]    r_ptr;
    logic [NUM_REQ-1:0] w_req_eff;
    logic [NUM_REQ-1:0] w_grant;
    logic [ID_W-1:0]    w_idx;
    logic               w_any;
    wt_addr_t           w_sel;
    logic               w_oor;
    wt_addr_t           r_last_addr;
    logic               r_s1_valid;
    logic [ID_W-1:0]    r_s1_id;
    logic               r_s1_err;
    logic               r_rd_valid;
    logic [ID_W-1:0]    r_rd_id;
    wt_data_t           r_rd_data;
    logic               r_rd_err;

    // Reset and en both suppress new grants; in-flight reads are unaffected by en.
    assign w_req_eff = (i_en && !i_rst) ? i_req : {NUM_REQ{1'b0}};

    rr_priority_select #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_sel (
        .i_req   (w_req_eff),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    assign w_sel = i_wave_sel[int'(w_idx)*WT_ADDR_W +: WT_ADDR_W];

`ifdef WAVETABLE_OFFSET_RANGE_CHECK_EN
    assign w_oor = w_any && !addr_in_range(w_sel);
`else
    assign w_oor = 1'b0;
`endif

    assign o_grant    = w_grant;
    assign o_rom_re   = w_any && !w_oor;
    assign o_rom_addr = w_any ? w_sel : r_last_addr;

    // Priority pointer, held ROM address and stage-1 tag alongside the ROM read.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ptr       <= '0;
            r_last_addr <= '0;
            r_s1_valid  <= 1'b0;
            r_s1_id     <= '0;
            r_s1_err    <= 1'b0;
        end else begin
            r_s1_valid <= w_any;
            r_s1_err   <= w_oor;
            if (w_any) begin
                r_ptr       <= (w_idx == ID_W'(NUM_REQ - 1)) ? ID_W'(0) : w_idx + ID_W'(1);
                r_last_addr <= w_sel;
                r_s1_id     <= w_idx;
            end
        end
    end

    // Stage 2: result registers; id/data hold between valid pulses.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rd_valid <= 1'b0;
            r_rd_id    <= '0;
            r_rd_data  <= '0;
            r_rd_err   <= 1'b0;
        end else begin
            r_rd_valid <= r_s1_valid;
            r_rd_err   <= r_s1_valid && r_s1_err;
            if (r_s1_valid) begin
                r_rd_id   <= r_s1_id;
                r_rd_data <= r_s1_err ? {WT_DATA_W{1'b0}} : i_rom_data;
            end
        end
    end

    assign o_rd_valid = r_rd_valid;
    assign o_rd_id    = r_rd_id;
    assign o_rd_data  = r_rd_data;
    assign o_rd_err   = r_rd_err;

endmodule

// File: tb/tb_wavetable_offset_arbiter.sv
// Directed bench for wavetable_offset_arbiter with a behavioural 1-cycle ROM.
module tb_wavetable_offset_arbiter;

    logic        clk;
    logic        rst;
    logic        en;
    logic [7:0]  req;
    logic [39:0] wave_sel;
    logic [7:0]  grant;
    logic        rom_re;
    logic [4:0]  rom_addr;
    logic [7:0]  rom_data;
    logic        rd_valid;
    logic [2:0]  rd_id;
    logic [7:0]  rd_data;
    logic        rd_err;

    int checks = 0;
    int errors = 0;

    wavetable_offset_arbiter #(.NUM_REQ(8)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_en       (en),
        .i_req      (req),
        .i_wave_sel (wave_sel),
        .o_grant    (grant),
        .o_rom_re   (rom_re),
        .o_rom_addr (rom_addr),
        .i_rom_data (rom_data),
        .o_rd_valid (rd_valid),
        .o_rd_id    (rd_id),
        .o_rd_data  (rd_data),
        .o_rd_err   (rd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM contents: a*7 + 0x2B, so ROM[3] = 0x40.
    function automatic logic [7:0] rom_f(input int a);
        return 8'((a * 7 + 43) & 255);
    endfunction

    initial rom_data = 8'h00;
    always @(posedge clk) begin
        if (rom_re) rom_data <= rom_f(int'(rom_addr));
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #4;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_grant"}, 32'(grant), 32'h0);
        check({tag, "_rom_re"}, 32'(rom_re), 32'h0);
        check({tag, "_rom_addr"}, 32'(rom_addr), 32'h0);
        check({tag, "_rd_valid"}, 32'(rd_valid), 32'h0);
        check({tag, "_rd_id"}, 32'(rd_id), 32'h0);
        check({tag, "_rd_data"}, 32'(rd_data), 32'h0);
        check({tag, "_rd_err"}, 32'(rd_err), 32'h0);
    endtask

    initial begin
        int g;
        int r;
        rst = 1'b1; en = 1'b1; req = 8'h00; wave_sel = 40'h0;
        tick(); tick(); settle();
        check_all_zero("reset");

        // Single request, voice 0 reads ROM[3]
        tick(); rst = 1'b0; wave_sel[4:0] = 5'd3; req = 8'h01; settle();
        check("t1_grant", 32'(grant), 32'h01);
        check("t1_rom_re", 32'(rom_re), 32'h1);
        check("t1_rom_addr", 32'(rom_addr), 32'd3);
        tick(); req = 8'h00; settle();
        check("t1_idle_grant", 32'(grant), 32'h0);
        check("t1_idle_rom_re", 32'(rom_re), 32'h0);
        check("t1_addr_hold", 32'(rom_addr), 32'd3);
        tick(); settle();
        check("t1_rd_valid", 32'(rd_valid), 32'h1);
        check("t1_rd_id", 32'(rd_id), 32'h0);
        check("t1_rd_data", 32'(rd_data), 32'h40);
        check("t1_rd_err", 32'(rd_err), 32'h0);
        tick(); settle();
        check("t1_valid_drop", 32'(rd_valid), 32'h0);
        check("t1_data_hold", 32'(rd_data), 32'h40);

        // All voices requesting from a fresh pointer
        tick(); rst = 1'b1; settle();
        check("t2_rst_grant", 32'(grant), 32'h0);
        tick(); rst = 1'b0;
        for (int i = 0; i < 8; i++) wave_sel[i*5 +: 5] = 5'(i);
        for (int k = 0; k < 11; k++) begin
            req = (k < 9) ? 8'hFF : 8'h00;
            settle();
            g = k % 8;
            check("t2_grant", 32'(grant), (k < 9) ? (32'h1 << g) : 32'h0);
            if (k < 9) check("t2_rom_addr", 32'(rom_addr), 32'(g));
            check("t2_rd_valid", 32'(rd_valid), (k >= 2) ? 32'h1 : 32'h0);
            if (k >= 2) begin
                r = (k - 2) % 8;
                check("t2_rd_id", 32'(rd_id), 32'(r));
                check("t2_rd_data", 32'(rd_data), 32'(rom_f(r)));
            end
            tick();
        end

        // req=0x90 alternates voices 4 and 7
        for (int k = 0; k < 6; k++) begin
            req = (k < 4) ? 8'h90 : 8'h00;
            settle();
            g = (k % 2 == 0) ? 4 : 7;
            check("t3_grant", 32'(grant), (k < 4) ? (32'h1 << g) : 32'h0);
            if (k >= 2) begin
                r = ((k - 2) % 2 == 0) ? 4 : 7;
                check("t3_rd_valid", 32'(rd_valid), 32'h1);
                check("t3_rd_id", 32'(rd_id), 32'(r));
                check("t3_rd_data", 32'(rd_data), 32'(rom_f(r)));
            end
            tick();
        end

        // en low with two reads in flight; pointer saved at 2
        req = 8'hFF; settle();
        check("t4_grant0", 32'(grant), 32'h01);
        tick(); settle();
        check("t4_grant1", 32'(grant), 32'h02);
        tick(); en = 1'b0; settle();
        check("t4_blk_grant", 32'(grant), 32'h0);
        check("t4_blk_rom_re", 32'(rom_re), 32'h0);
        check("t4_rdv0", 32'(rd_valid), 32'h1);
        check("t4_rdid0", 32'(rd_id), 32'h0);
        tick(); settle();
        check("t4_blk_grant2", 32'(grant), 32'h0);
        check("t4_rdv1", 32'(rd_valid), 32'h1);
        check("t4_rdid1", 32'(rd_id), 32'h1);
        check("t4_rddata1", 32'(rd_data), 32'(rom_f(1)));
        tick(); settle();
        check("t4_rdv_idle", 32'(rd_valid), 32'h0);
        tick(); en = 1'b1; settle();
        check("t4_resume", 32'(grant), 32'h04);
        tick(); req = 8'h00; settle();
        check("t4_idle", 32'(grant), 32'h0);
        tick(); settle();
        check("t4_rdid2", 32'(rd_id), 32'h2);
        check("t4_rdv2", 32'(rd_valid), 32'h1);

        // Reset with two reads in flight
        tick(); req = 8'hFF; settle();
        check("t5_grant3", 32'(grant), 32'h08);
        tick(); settle();
        check("t5_grant4", 32'(grant), 32'h10);
        tick(); rst = 1'b1; settle();
        check("t5_rst_grant", 32'(grant), 32'h0);
        check("t5_rdid3", 32'(rd_id), 32'h3);
        tick(); settle();
        check_all_zero("t5_after_rst");
        tick(); rst = 1'b0; req = 8'h0C; settle();
        check("t5_first_grant", 32'(grant), 32'h04);
        check("t5_no_rdv", 32'(rd_valid), 32'h0);
        tick(); req = 8'h00; settle();
        check("t5_flushed", 32'(rd_valid), 32'h0);
        tick(); settle();
        check("t5_rdv_new", 32'(rd_valid), 32'h1);
        check("t5_rdid_new", 32'(rd_id), 32'h2);

        // Out-of-range index on voice 2
        tick(); wave_sel[14:10] = 5'd30; req = 8'h04; settle();
        check("t6_grant", 32'(grant), 32'h04);
        check("t6_rom_addr", 32'(rom_addr), 32'd30);
`ifdef WAVETABLE_OFFSET_RANGE_CHECK_EN
        check("t6_rom_re", 32'(rom_re), 32'h0);
`else
        check("t6_rom_re", 32'(rom_re), 32'h1);
`endif
        tick(); req = 8'h00; settle();
        check("t6_rdv_early", 32'(rd_valid), 32'h0);
        tick(); settle();
        check("t6_rdv", 32'(rd_valid), 32'h1);
        check("t6_rdid", 32'(rd_id), 32'h2);
`ifdef WAVETABLE_OFFSET_RANGE_CHECK_EN
        check("t6_rd_data", 32'(rd_data), 32'h0);
        check("t6_rd_err", 32'(rd_err), 32'h1);
`else
        check("t6_rd_err", 32'(rd_err), 32'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
